// File: rtl/mem_lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit: opcodes, bus widths,
// FSM encodings, byte-lane selects and opcode classification helpers.
package mem_lsu_pkg;

    typedef logic [31:0] reg_bus_t;
    typedef logic [4:0]  reg_addr_t;

    localparam reg_bus_t  ZERO_WORD     = 32'h0000_0000;
    localparam logic      WRITE_DISABLE = 1'b0;
    localparam reg_addr_t NOP_REG_ADDR  = 5'b00000;

    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_LB_OP   = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP  = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP   = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP  = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP   = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP   = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Big-endian lanes: address offset 0 lives in the most significant byte.
    localparam logic [3:0] SEL_NONE    = 4'b0000;
    localparam logic [3:0] SEL_BYTE_0  = 4'b1000;
    localparam logic [3:0] SEL_BYTE_1  = 4'b0100;
    localparam logic [3:0] SEL_BYTE_2  = 4'b0010;
    localparam logic [3:0] SEL_BYTE_3  = 4'b0001;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

    function automatic logic is_load(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        if ((op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP))
            r = addr_lo[0];
        else if ((op == EXE_LW_OP) || (op == EXE_SW_OP))
            r = |addr_lo;
        return r;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane logic: store byte enables and replicated data,
// plus extraction and sign/zero extension of load data.
module mem_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [3:0]  byte_sel;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_sel = SEL_BYTE_0;
        byte_val = load_word[31:24];
        case (addr_lo)
            2'b00: begin byte_sel = SEL_BYTE_0; byte_val = load_word[31:24]; end
            2'b01: begin byte_sel = SEL_BYTE_1; byte_val = load_word[23:16]; end
            2'b10: begin byte_sel = SEL_BYTE_2; byte_val = load_word[15:8];  end
            default: begin byte_sel = SEL_BYTE_3; byte_val = load_word[7:0]; end
        endcase
    end

    // Halfwords use addr[1] only; addr[0] is dropped, which forces alignment.
    assign half_val = addr_lo[1] ? load_word[15:0] : load_word[31:16];

    always_comb begin
        sel       = SEL_NONE;
        wdata     = ZERO_WORD;
        load_data = ZERO_WORD;
        case (aluop)
            EXE_LB_OP: begin
                sel       = byte_sel;
                load_data = {{24{byte_val[7]}}, byte_val};
            end
            EXE_LBU_OP: begin
                sel       = byte_sel;
                load_data = {24'h0, byte_val};
            end
            EXE_LH_OP: begin
                sel       = addr_lo[1] ? SEL_HALF_LO : SEL_HALF_HI;
                load_data = {{16{half_val[15]}}, half_val};
            end
            EXE_LHU_OP: begin
                sel       = addr_lo[1] ? SEL_HALF_LO : SEL_HALF_HI;
                load_data = {16'h0, half_val};
            end
            EXE_LW_OP: begin
                sel       = SEL_WORD;
                load_data = load_word;
            end
            EXE_SB_OP: begin
                sel   = byte_sel;
                wdata = {4{store_data[7:0]}};
            end
            EXE_SH_OP: begin
                sel   = addr_lo[1] ? SEL_HALF_LO : SEL_HALF_HI;
                wdata = {2{store_data[15:0]}};
            end
            EXE_SW_OP: begin
                sel   = SEL_WORD;
                wdata = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: bus master FSM (IDLE/WAIT/HOLD), ack timeout and
// MEM/WB passthrough. Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        mem_whilo_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_whilo,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stallreq,
    output logic        bus_err,
    output logic [1:0]  fsm_state
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        misalign_q;
    logic        load_op;
    logic        mem_op;
    logic        misalign;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic [31:0] load_data_c;

    assign load_op   = is_load(mem_aluop_i);
    assign mem_op    = load_op | is_store(mem_aluop_i);
    assign fsm_state = state;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign   = is_misaligned(mem_aluop_i, mem_addr_i[1:0]);
    assign misalign_o = misalign_q;
`else
    assign misalign   = 1'b0;
`endif

    // The EX/MEM register is stalled through HOLD, so aluop/addr still
    // describe this access when rdata_q is aligned for writeback.
    mem_align u_align (
        .aluop      (mem_aluop_i),
        .addr_lo    (mem_addr_i[1:0]),
        .store_data (mem_reg2_i),
        .load_word  (rdata_q),
        .sel        (sel_c),
        .wdata      (wdata_c),
        .load_data  (load_data_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            rdata_q    <= ZERO_WORD;
            misalign_q <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_sel    <= SEL_NONE;
            bus_addr   <= ZERO_WORD;
            bus_wdata  <= ZERO_WORD;
            bus_err    <= 1'b0;
        end else begin
            bus_err    <= 1'b0;
            misalign_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        if (misalign) begin
                            misalign_q <= 1'b1;
                            state      <= ST_HOLD;
                        end else begin
                            bus_addr  <= {mem_addr_i[31:2], 2'b00};
                            bus_sel   <= sel_c;
                            bus_we    <= ~load_op;
                            bus_wdata <= wdata_c;
                            bus_req   <= 1'b1;
                            state     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_sel <= SEL_NONE;
                        rdata_q <= bus_rdata;
                        state   <= ST_HOLD;
                    end else if (cnt == TIMEOUT_LAST) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_sel <= SEL_NONE;
                        bus_err <= 1'b1;
                        state   <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    cnt   <= 8'd0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // bus_err and misalign_q are high only in the HOLD that follows an abort.
    always_comb begin
        wb_wd    = mem_wd_i;
        wb_wreg  = mem_wreg_i;
        wb_wdata = mem_wdata_i;
        wb_hi    = mem_hi_i;
        wb_lo    = mem_lo_i;
        wb_whilo = mem_whilo_i;
        stallreq = 1'b0;
        if (rst) begin
            wb_wd    = NOP_REG_ADDR;
            wb_wreg  = WRITE_DISABLE;
            wb_wdata = ZERO_WORD;
            wb_hi    = ZERO_WORD;
            wb_lo    = ZERO_WORD;
            wb_whilo = WRITE_DISABLE;
        end else if (mem_op) begin
            case (state)
                ST_IDLE, ST_WAIT: stallreq = 1'b1;
                ST_HOLD: begin
                    if (load_op)
                        wb_wdata = load_data_c;
                    if (bus_err || misalign_q)
                        wb_wreg = WRITE_DISABLE;
                end
                default: stallreq = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs.
- Drives the data-bus master handshake, aligns and sign-extends load data, and builds byte lanes for stores.
- Raises stallreq to the pipeline controller until the access completes.
- HI/LO and ALU results pass through to the MEM/WB register unchanged.

Parameters:
- ACK_TIMEOUT, 255: max cycles in WAIT before the access is aborted with bus_err; 8-bit counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- mem_wd_i  in  5  destination register address
- mem_wreg_i  in  1  register write enable
- mem_wdata_i  in  32  ALU result
- mem_hi_i / mem_lo_i  in  32 each  HI/LO values
- mem_whilo_i  in  1  HI/LO write enable
- mem_aluop_i  in  8  operation code (`EXE_*_OP)
- mem_addr_i  in  32  effective address
- mem_reg2_i  in  32  store source data
- wb_wd / wb_wreg / wb_wdata / wb_hi / wb_lo / wb_whilo  out  5/1/32/32/32/1  to MEM/WB
- bus_req  out  1  request valid
- bus_we  out  1  write
- bus_addr  out  32  word-aligned address
- bus_sel  out  4  byte enables
- bus_wdata  out  32  store data
- bus_rdata  in  32  read data
- bus_ack  in  1  one-cycle completion
- stallreq  out  1  stall request to pipeline control
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - FSM goes to IDLE; bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err, the timeout counter and rdata_q clear to 0.
  - While rst=1, wb_* are forced to `NOPRegAddr / `WriteDisable / `ZeroWord, and stallreq=0.
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. All other opcodes pass inputs straight through to wb_* combinationally, with stallreq=0.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - If a memory op is present: stallreq=1 (combinational).
  - On the clock edge, register bus_addr={addr[31:2],2'b00}, bus_sel, bus_we (1 for stores), bus_wdata; set bus_req<=1; go to WAIT.
- WAIT:
  - stallreq=1.
  - On bus_ack: bus_req<=0, bus_we<=0, bus_sel<=0, rdata_q<=bus_rdata, go to HOLD.
  - Else increment the counter. When it reaches ACK_TIMEOUT: drop bus_req, pulse bus_err for one cycle, go to HOLD with wb_wreg forced to 0.
- HOLD:
  - stallreq=0, so the pipeline advances this cycle.
  - Loads: wb_wdata = aligned rdata_q. Stores: wb_wreg passes through mem_wreg_i (normally 0).
  - Next state is IDLE; the counter clears.
- Minimum latency: 3 cycles (IDLE, WAIT with ack on the first WAIT cycle, HOLD).
- bus_req stays high until ack. Address, sel and data are stable while bus_req=1.
- Byte lanes are big-endian:
  - Byte: addr[1:0]=00 → sel 1000, data bits [31:24]; 11 → sel 0001, bits [7:0].
  - Halfword: addr[1]=0 → sel 1100, upper half.
  - Word: sel 1111.
- Store data is replicated into every lane ({4{b}}, {2{h}}).
- LB and LH sign-extend; LBU and LHU zero-extend.
- bus_ack outside WAIT is ignored.
- Reset asserted in WAIT aborts the access: bus_req drops the next edge and no bus_err is raised.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, is not issued.
  - The FSM goes IDLE→HOLD in one cycle with wb_wreg=0, and output misalign_o (1 bit, reset 0) pulses high in HOLD.
- Undefined: low address bits below the access size are ignored (forced aligned); the misalign_o port is absent.

Decomposition:
- Shared package/define file holds:
  - `EXE_LB_OP … `EXE_SW_OP opcodes
  - `RegBus, `RegAddrBus, `ZeroWord, `WriteDisable, `NOPRegAddr
  - FSM state encodings
  - byte-select constants
- One sub-module, mem_align: purely combinational. Takes aluop and addr[1:0]; produces sel, replicated store data, and extracted/extended load data.
- The FSM and counter stay in mem_lsu.

Test Plan:
- ADDU passthrough, wdata=0x1234, wreg=1 → wb_wdata=0x1234 on the same cycle; stallreq=0; bus_req never rises.
- LB, addr=0x103, rdata=0x000000F0, ack on the 1st WAIT cycle → bus_addr=0x100, sel=0001; wb_wdata=0xFFFFFFF0 in HOLD; stallreq high exactly 2 cycles.
- SH, addr=0x202, reg2=0xABCD1234 → bus_we=1, sel=0011, bus_wdata=0x12341234; ack after 5 wait cycles → stallreq high 7 cycles.
- LW with ack never asserted, ACK_TIMEOUT=4 → bus_err pulses once after 4 WAIT cycles; wb_wreg=0 in HOLD; FSM returns to IDLE.
- rst=1 during WAIT of an LHU → next edge: bus_req=0, FSM in IDLE, stallreq=0, bus_err=0; a later ack is ignored.
- With MEM_ALIGN_CHECK_EN, LW addr=0x301 → no bus_req; misalign_o=1 for one cycle; wb_wreg=0; stallreq high 1 cycle.
